imem_loader: RTL

Instruction-memory responder for the single-cycle CPU core's fetch port. It is loaded with a program over a byte-wide valid/ready stream and assembles bytes into 32-bit little-endian words. After loading it serves fetches: registered read of `instr_addr`, returned on `instr_data` one clock later. It also drives the core's `last_pc` and a `run` flag that marks a program as ready.

---
 rtl/imem_loader_if.sv | 31 +++
 rtl/imem_loader.sv | 139 +++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - load stream and fetch port bundle for imem_loader
//
// Purpose: groups the byte-wide program load stream and the core fetch port.
// Signals:
//   load_valid/load_ready/load_byte/load_last : byte load handshake
//   instr_addr/instr_data                     : fetch word address / registered data
//   last_pc/run/overflow                      : program status toward the core
// Modports:
//   master : loader + core side (drives load stream and instr_addr)
//   slave  : imem_loader side
interface imem_loader_if;
  logic        load_valid;
  logic        load_ready;
  logic [7:0]  load_byte;
  logic        load_last;
  logic [31:0] instr_addr;
  logic [31:0] instr_data;
  logic [31:0] last_pc;
  logic        run;
  logic        overflow;

  modport master (
    output load_valid, load_byte, load_last, instr_addr,
    input  load_ready, instr_data, last_pc, run, overflow
  );

  modport slave (
    input  load_valid, load_byte, load_last, instr_addr,
    output load_ready, instr_data, last_pc, run, overflow
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - instruction memory loaded over a byte stream, serving core fetches
//
// Purpose: assembles little-endian program bytes into 32-bit words, then
// serves registered one-cycle-latency fetches once the program is complete.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : imem_loader_if.slave (load stream, fetch port, status)
// Parameters:
//   ADDR_W : word address width, DEPTH = 2**ADDR_W words
//   NOP    : word returned for fetches outside RUN or outside memory
module imem_loader #(
  parameter int          ADDR_W = 8,
  parameter logic [31:0] NOP    = 32'h00000013
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus
);

  localparam int          DEPTH    = 2 ** ADDR_W;
  // 33-bit bound so the full 32-bit address is compared without truncation
  localparam logic [32:0] DEPTH_33 = 33'd1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q;
  logic [1:0]          byte_cnt_q;
  logic [23:0]         asm_q;      // lanes 0..2 of the word under assembly
  logic [31:0]         last_pc_q;
  logic                run_q;
  logic                overflow_q;
  logic [31:0]         instr_data_q;

  logic [31:0]         mem [DEPTH];

  logic                load_ready;
  logic                accept;
  logic                write_en;
  logic                full;
  logic                finish;
  logic [31:0]         wr_word;

  // ready depends on state only
  assign load_ready = (state_q != RUN);
  assign accept     = bus.load_valid & load_ready;

  // Lanes above byte_cnt are always zero in asm_q because it is cleared on
  // every word write, so OR-ing in the new byte yields a zero-padded word.
  assign wr_word  = {8'h00, asm_q} | (32'(bus.load_byte) << {byte_cnt_q, 3'b000});
  assign write_en = accept & ((byte_cnt_q == 2'd3) | bus.load_last);
  assign full     = write_en & (&wr_ptr_q) & ~bus.load_last;
  assign finish   = accept & (bus.load_last | full);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = finish ? RUN : LOAD;
        end
      end
      LOAD: begin
        if (finish) begin
          state_d = RUN;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // load datapath and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      byte_cnt_q <= 2'd0;
      asm_q      <= 24'h0;
      last_pc_q  <= 32'h0;
      run_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else if (accept) begin
      if (write_en) begin
        wr_ptr_q   <= wr_ptr_q + ADDR_W'(1);
        byte_cnt_q <= 2'd0;
        asm_q      <= 24'h0;
      end else begin
        byte_cnt_q <= byte_cnt_q + 2'd1;
        asm_q      <= wr_word[23:0];
      end
      if (finish) begin
        last_pc_q <= 32'(wr_ptr_q);
        run_q     <= 1'b1;
      end
      if (full) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // program storage, deliberately not reset so contents survive rst
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[wr_ptr_q] <= wr_word;
    end
  end

  // registered fetch; uses the registered state so the edge that sets run
  // still returns NOP
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_data_q <= NOP;
    end else if ((state_q == RUN) && ({1'b0, bus.instr_addr} < DEPTH_33)) begin
      instr_data_q <= mem[bus.instr_addr[ADDR_W-1:0]];
    end else begin
      instr_data_q <= NOP;
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.instr_data = instr_data_q;
  assign bus.last_pc    = last_pc_q;
  assign bus.run        = run_q;
  assign bus.overflow   = overflow_q;

endmodule
